explosion_controller: RTL and testbench
=======================================

Name: explosion_controller

Overview:
- Turns bomb-detonation events into explosion footprints on the shared tile-map RAM, then clears them after a hold time.
- Queues detonation events and converts each pixel location to a tile.
- Walks the centre tile and four arms (up, down, left, right) up to RANGE tiles, stopping at hard walls and destroying breakable blocks.
- Is one requester on the map RAM arbiter.

Parameters:
- RANGE, 2: arm length in tiles.
- HOLD_CYCLES, 50000000: clocks an explosion stays on the map before clearing.
- MAP_COLS, 33: map width in tiles.
- MAP_ROWS, 15: map height in tiles.
- X_OFS, 48: pixel x of tile column 0.
- Y_OFS, 32: pixel y of tile row 0.
- FIFO_DEPTH, 4: detonation event queue depth (power of 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low (0 = reset).
- ev_valid  in  1  single-cycle detonation pulse.
- ev_x  in  10  bomb pixel x (top-left), sampled with ev_valid.
- ev_y  in  10  bomb pixel y, sampled with ev_valid.
- map_req  out  1  map access request.
- map_gnt  in  1  arbiter grant; access occurs in a cycle with map_req && map_gnt.
- map_we  out  1  1 = write, 0 = read.
- map_addr  out  9  tile index, row*MAP_COLS + col.
- map_wdata  out  2  tile code to write.
- map_rdata  in  2  read data, valid the cycle after the granted read.
- busy  out  1  FSM not in IDLE.
- blast_active  out  1  high during HOLD.
- blast_done  out  1  one-cycle pulse when clearing finishes.
- ev_overflow  out  1  sticky: an event was dropped.

Behaviour:
- Tile codes: 00 empty, 01 hard wall, 10 breakable, 11 explosion.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, record list empty. Reset mid-operation aborts immediately with no write-back. map_req is 0 the cycle after reset is sampled low. Map contents are left as they are.
- FIFO:
  - ev_valid pushes {ev_x, ev_y}.
  - If the FIFO is full and no pop happens that cycle, the event is dropped and ev_overflow is set.
  - A push and a pop in the same cycle on a full FIFO is accepted.
- Conversion:
  - col = (ev_x - X_OFS) >> 4, row = (ev_y - Y_OFS) >> 4.
  - If ev_x < X_OFS, ev_y < Y_OFS, col >= MAP_COLS or row >= MAP_ROWS, the event is discarded and the FSM returns to IDLE.
- FSM states: IDLE, POP, CENTER_WR, ARM_RD, ARM_WAIT, ARM_WR, HOLD, CLR_WR.
  - IDLE: if the FIFO is non-empty, go to POP.
  - POP: dequeue, register row/col, clear the record list and the arm index. Next state is CENTER_WR. An event pushed into an empty FIFO at cycle T gives map_req=1 at T+2.
  - CENTER_WR: request a write of 11 to the centre tile and record it. On grant, go to ARM_RD with dir=up and d=1.
  - ARM_RD: compute the neighbour at distance d in dir.
    - If it is off-map (row-d < 0, row+d >= MAP_ROWS, col-d < 0, col+d >= MAP_COLS), end the arm.
    - Otherwise request a read; on grant, go to ARM_WAIT.
  - ARM_WAIT: sample map_rdata.
    - 01: end the arm.
    - 10: go to ARM_WR, then end the arm.
    - 00 or 11: go to ARM_WR, then d+1. If d reaches RANGE, end the arm.
  - ARM_WR: request a write of 11 and record the tile.
  - End of arm: advance dir in the order up, down, left, right. After right, go to HOLD.
  - HOLD: blast_active=1 and count HOLD_CYCLES clocks, then go to CLR_WR.
  - CLR_WR: write 00 to each recorded tile in record order, one per grant. After the last one, pulse blast_done and go to IDLE.
- Request rule: while map_req=1 and there is no grant, map_we, map_addr and map_wdata stay stable. The request may be held for any number of cycles.
- The record list holds 1+4*RANGE entries and cannot overflow.
- Events arriving during processing queue in the FIFO. They are served strictly in order after blast_done.

Test Plan:
- Open field: event at pixel (112,96) (tile col 4, row 4) on an all-00 map, gnt tied 1.
  -> Writes 11 at tiles (4,4), (4,3), (4,2), (4,5), (4,6), (3,4), (2,4), (5,4), (6,4).
  -> blast_active high for HOLD_CYCLES, then 9 writes of 00 in the same order, then blast_done pulse.
- Obstacles: 01 at (4,3) and 10 at (5,4).
  -> No write to (4,3) or (4,2).
  -> (5,4) is written 11, (6,4) is not read.
  -> (5,4) is 00 after clearing.
- Map edge: event at tile (0,0).
  -> No reads at negative coordinates; 5 tiles are written.
  -> An event at pixel x=40 causes no map access.
- Grant stall: gnt held 0 for 7 cycles at the first ARM_RD.
  -> map_addr, map_we and map_wdata stay stable.
  -> Exactly one read occurs on grant, and rdata is sampled the next cycle.
- Queue: 6 ev_valid pulses while busy.
  -> 4 are processed in order, 2 are dropped, ev_overflow=1 until reset.
- Reset low during HOLD.
  -> Next cycle busy=0, blast_active=0, map_req=0, FIFO empty.

Source files
------------

// File: rtl/explosion_controller.sv
// ----------------------------------------------------------------------------
// explosion_controller
//
// Turns bomb-detonation events into explosion footprints on the shared tile
// map.
//
// Detonations are queued in a small FIFO. Each event is converted from pixel
// to tile coordinates. The controller writes the explosion code (11) to the
// centre tile. It then walks the up, down, left and right arms up to RANGE
// tiles. A hard wall (01) stops an arm. A breakable block (10) is destroyed
// and also stops the arm. Every tile written is recorded. After HOLD_CYCLES
// the recorded tiles are cleared to 00 in the order they were written.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   ev_valid     one-cycle detonation pulse; ev_x / ev_y are sampled with it
//   ev_x, ev_y   bomb pixel position (top-left corner)
//   map_req      map access request to the arbiter
//   map_gnt      arbiter grant; an access happens when map_req && map_gnt
//   map_we       1 = write, 0 = read
//   map_addr     tile index, row*MAP_COLS + col
//   map_wdata    tile code to write
//   map_rdata    read data, valid the cycle after a granted read
//   busy         controller is not idle
//   blast_active explosion is being held on the map
//   blast_done   one-cycle pulse when clearing finishes
//   ev_overflow  sticky flag: an event was dropped because the queue was full
// ----------------------------------------------------------------------------
module explosion_controller #(
   parameter int RANGE       = 2,
   parameter int HOLD_CYCLES = 50000000,
   parameter int MAP_COLS    = 33,
   parameter int MAP_ROWS    = 15,
   parameter int X_OFS       = 48,
   parameter int Y_OFS       = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ev_valid,
   input  logic [9:0] ev_x,
   input  logic [9:0] ev_y,
   output logic       map_req,
   input  logic       map_gnt,
   output logic       map_we,
   output logic [8:0] map_addr,
   output logic [1:0] map_wdata,
   input  logic [1:0] map_rdata,
   output logic       busy,
   output logic       blast_active,
   output logic       blast_done,
   output logic       ev_overflow
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int NREC = 1 + 4 * RANGE;
   localparam int RW   = $clog2(NREC + 1);
   localparam int HW   = $clog2(HOLD_CYCLES + 1);

   localparam logic [9:0]        X_OFS_C  = 10'(X_OFS);
   localparam logic [9:0]        Y_OFS_C  = 10'(Y_OFS);
   localparam logic [5:0]        COLS_U   = 6'(MAP_COLS);
   localparam logic [5:0]        ROWS_U   = 6'(MAP_ROWS);
   localparam logic signed [7:0] COLS_S   = 8'(MAP_COLS);
   localparam logic signed [7:0] ROWS_S   = 8'(MAP_ROWS);
   localparam logic [3:0]        RANGE_C  = 4'(RANGE);
   localparam logic [HW-1:0]     HOLD_END = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_CENTER_WR, S_ARM_RD, S_ARM_WAIT, S_ARM_WR, S_HOLD, S_CLR_WR
   } state_t;

   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   // Tile index of (row, col) in the row-major map.
   function automatic logic [8:0] tile_addr(input logic [5:0] r, input logic [5:0] c);
      int a;
      a = int'(r) * MAP_COLS + int'(c);
      return 9'(a);
   endfunction

   state_t          state_q, state_d;
   dir_t            dir_q, dir_d;
   logic [3:0]      d_q, d_d;
   logic            last_q, last_d;
   logic [5:0]      row_q, row_d, col_q, col_d;
   logic [RW-1:0]   rec_cnt_q, rec_cnt_d, clr_idx_q, clr_idx_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            done_q, done_d;
   logic            ovf_q;
   logic [8:0]      rec_q [0:NREC-1];
   logic [19:0]     fifo_q [0:FIFO_DEPTH-1];
   logic [PW:0]     wr_ptr_q, rd_ptr_q;

   logic            fifo_empty_s, fifo_full_s, push_s, pop_s;
   logic [19:0]     head_s;
   logic [9:0]      dx_s, dy_s;
   logic [5:0]      ev_col_s, ev_row_s;
   logic            ev_in_map_s;
   logic signed [7:0] nrow_s, ncol_s, offs_s;
   logic            off_map_s;
   logic [8:0]      center_addr_s, nb_addr_s;
   state_t          arm_end_state_s;
   logic            rec_wr_s;
   logic [8:0]      rec_addr_s;
   logic            req_s, we_s;
   logic [8:0]      addr_s;
   logic [1:0]      wdata_s;

   // Queue status. The extra pointer bit tells full from empty.
   always_comb begin
      fifo_empty_s = (wr_ptr_q == rd_ptr_q);
      fifo_full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      pop_s        = (state_q == S_POP);
      // A full queue still accepts an event in a cycle that pops.
      push_s       = ev_valid && (!fifo_full_s || pop_s);
      head_s       = fifo_q[rd_ptr_q[PW-1:0]];
   end

   // Pixel-to-tile conversion of the event at the head of the queue.
   always_comb begin
      dx_s        = head_s[19:10] - X_OFS_C;
      dy_s        = head_s[9:0]   - Y_OFS_C;
      ev_col_s    = 6'(dx_s >> 4);
      ev_row_s    = 6'(dy_s >> 4);
      ev_in_map_s = (head_s[19:10] >= X_OFS_C) && (head_s[9:0] >= Y_OFS_C) &&
                    (ev_col_s < COLS_U) && (ev_row_s < ROWS_U);
   end

   // Neighbour at distance d in the current arm direction, with signed bounds check.
   always_comb begin
      offs_s = $signed({4'b0000, d_q});
      nrow_s = $signed({2'b00, row_q});
      ncol_s = $signed({2'b00, col_q});
      case (dir_q)
         D_UP:    nrow_s = nrow_s - offs_s;
         D_DOWN:  nrow_s = nrow_s + offs_s;
         D_LEFT:  ncol_s = ncol_s - offs_s;
         D_RIGHT: ncol_s = ncol_s + offs_s;
         default: nrow_s = nrow_s;
      endcase
      off_map_s       = (nrow_s < 8'sd0) || (nrow_s >= ROWS_S) ||
                        (ncol_s < 8'sd0) || (ncol_s >= COLS_S);
      center_addr_s   = tile_addr(row_q, col_q);
      nb_addr_s       = tile_addr(nrow_s[5:0], ncol_s[5:0]);
      arm_end_state_s = (dir_q == D_RIGHT) ? S_HOLD : S_ARM_RD;
   end

   // Next-state and map-request logic.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      d_d        = d_q;
      last_d     = last_q;
      row_d      = row_q;
      col_d      = col_q;
      rec_cnt_d  = rec_cnt_q;
      clr_idx_d  = clr_idx_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      rec_wr_s   = 1'b0;
      rec_addr_s = 9'd0;
      req_s      = 1'b0;
      we_s       = 1'b0;
      addr_s     = 9'd0;
      wdata_s    = 2'b00;
      case (state_q)
         S_IDLE: begin
            // An event arriving this cycle is already in the queue by the POP cycle.
            if (!fifo_empty_s || ev_valid) begin
               state_d = S_POP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_POP: begin
            if (ev_in_map_s) begin
               row_d     = ev_row_s;
               col_d     = ev_col_s;
               rec_cnt_d = '0;
               clr_idx_d = '0;
               dir_d     = D_UP;
               d_d       = 4'd1;
               state_d   = S_CENTER_WR;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_CENTER_WR: begin
            req_s   = 1'b1;
            we_s    = 1'b1;
            addr_s  = center_addr_s;
            wdata_s = 2'b11;
            if (map_gnt) begin
               rec_wr_s   = 1'b1;
               rec_addr_s = center_addr_s;
               rec_cnt_d  = rec_cnt_q + RW'(1);
               dir_d      = D_UP;
               d_d        = 4'd1;
               state_d    = S_ARM_RD;
            end else begin
               state_d    = S_CENTER_WR;
            end
         end
         S_ARM_RD: begin
            if (off_map_s) begin
               state_d = arm_end_state_s;
               dir_d   = dir_t'(dir_q + 2'd1);
               d_d     = 4'd1;
               hold_d  = '0;
            end else begin
               req_s  = 1'b1;
               addr_s = nb_addr_s;
               if (map_gnt) begin
                  state_d = S_ARM_WAIT;
               end else begin
                  state_d = S_ARM_RD;
               end
            end
         end
         S_ARM_WAIT: begin
            case (map_rdata)
               2'b01: begin
                  state_d = arm_end_state_s;
                  dir_d   = dir_t'(dir_q + 2'd1);
                  d_d     = 4'd1;
                  hold_d  = '0;
               end
               2'b10: begin
                  last_d  = 1'b1;
                  state_d = S_ARM_WR;
               end
               default: begin
                  last_d  = (d_q == RANGE_C);
                  state_d = S_ARM_WR;
               end
            endcase
         end
         S_ARM_WR: begin
            req_s   = 1'b1;
            we_s    = 1'b1;
            addr_s  = nb_addr_s;
            wdata_s = 2'b11;
            if (map_gnt) begin
               rec_wr_s   = 1'b1;
               rec_addr_s = nb_addr_s;
               rec_cnt_d  = rec_cnt_q + RW'(1);
               if (last_q) begin
                  state_d = arm_end_state_s;
                  dir_d   = dir_t'(dir_q + 2'd1);
                  d_d     = 4'd1;
                  hold_d  = '0;
               end else begin
                  d_d     = d_q + 4'd1;
                  state_d = S_ARM_RD;
               end
            end else begin
               state_d = S_ARM_WR;
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_END) begin
               clr_idx_d = '0;
               state_d   = S_CLR_WR;
            end else begin
               hold_d    = hold_q + HW'(1);
            end
         end
         S_CLR_WR: begin
            req_s   = 1'b1;
            we_s    = 1'b1;
            addr_s  = rec_q[clr_idx_q];
            wdata_s = 2'b00;
            if (map_gnt) begin
               if (clr_idx_q == rec_cnt_q - RW'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  clr_idx_d = clr_idx_q + RW'(1);
               end
            end else begin
               state_d = S_CLR_WR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         dir_q     <= D_UP;
         d_q       <= 4'd1;
         last_q    <= 1'b0;
         row_q     <= 6'd0;
         col_q     <= 6'd0;
         rec_cnt_q <= '0;
         clr_idx_q <= '0;
         hold_q    <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         d_q       <= d_d;
         last_q    <= last_d;
         row_q     <= row_d;
         col_q     <= col_d;
         rec_cnt_q <= rec_cnt_d;
         clr_idx_q <= clr_idx_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + (PW + 1)'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + (PW + 1)'(1);
         end
         if (ev_valid && !push_s) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Queue payload and record-list storage; validity is tracked by the pointers and counters.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_q[wr_ptr_q[PW-1:0]] <= {ev_x, ev_y};
      end
      if (rec_wr_s) begin
         rec_q[rec_cnt_q] <= rec_addr_s;
      end
   end

   assign map_req      = req_s;
   assign map_we       = we_s;
   assign map_addr     = addr_s;
   assign map_wdata    = wdata_s;
   assign busy         = (state_q != S_IDLE);
   assign blast_active = (state_q == S_HOLD);
   assign blast_done   = done_q;
   assign ev_overflow  = ovf_q;

endmodule

// File: tb/tb_explosion_controller.sv
// ----------------------------------------------------------------------------
// tb_explosion_controller
//
// Bench for explosion_controller. It holds a behavioural tile RAM and a
// reference planner. For each accepted event, the planner walks the footprint
// rules over a shadow copy of the map. It builds the exact list of map
// accesses expected: reads, writes of 11, and the clearing writes. Every
// granted access from the DUT is compared against that list in order.
// ----------------------------------------------------------------------------
module tb_explosion_controller;

   localparam int RANGE = 2;
   localparam int HOLD  = 20;
   localparam int COLS  = 33;
   localparam int ROWS  = 15;
   localparam int XO    = 48;
   localparam int YO    = 32;
   localparam int NT    = COLS * ROWS;

   typedef struct packed {
      logic       we;
      logic [8:0] addr;
      logic [1:0] data;
   } acc_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ev_valid = 1'b0;
   logic [9:0] ev_x = 10'd0;
   logic [9:0] ev_y = 10'd0;
   logic       map_req, map_we, map_gnt;
   logic [8:0] map_addr;
   logic [1:0] map_wdata, map_rdata;
   logic       busy, blast_active, blast_done, ev_overflow;

   logic       gnt_man = 1'b1;
   logic       gnt_rnd = 1'b1;
   logic       gnt_rand_en = 1'b0;
   assign map_gnt = gnt_rand_en ? gnt_rnd : gnt_man;

   logic [1:0] mem    [0:NT-1];
   logic [1:0] shadow [0:NT-1];
   logic       ld_en = 1'b0;
   logic [1:0] rdata_q = 2'b00;
   assign map_rdata = rdata_q;

   acc_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   act_cnt, done_cnt, w11_cnt, w00_cnt, n_acc, busy_cnt, mism, n;
   logic       p_pend = 1'b0;
   logic       p_we;
   logic [8:0] p_addr;
   logic [1:0] p_data;

   explosion_controller #(
      .RANGE(RANGE), .HOLD_CYCLES(HOLD), .MAP_COLS(COLS), .MAP_ROWS(ROWS),
      .X_OFS(XO), .Y_OFS(YO), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_x(ev_x), .ev_y(ev_y),
      .map_req(map_req), .map_gnt(map_gnt), .map_we(map_we), .map_addr(map_addr),
      .map_wdata(map_wdata), .map_rdata(map_rdata), .busy(busy),
      .blast_active(blast_active), .blast_done(blast_done), .ev_overflow(ev_overflow)
   );

   always #5 clk = ~clk;

   // Tile RAM: bulk load from the shadow map, otherwise serve granted accesses.
   always @(posedge clk) begin
      if (ld_en) begin
         for (int i = 0; i < NT; i++) mem[i] <= shadow[i];
      end else if (map_req && map_gnt) begin
         if (map_we) mem[map_addr] <= map_wdata;
         else        rdata_q <= mem[map_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample on the falling edge, then return just after the rising edge.
   task automatic tick();
      acc_t e;
      @(negedge clk);
      if (blast_active) act_cnt++;
      if (blast_done)   done_cnt++;
      if (reset && p_pend && map_req) begin
         chk("stall_we",    32'(map_we),    32'(p_we));
         chk("stall_addr",  32'(map_addr),  32'(p_addr));
         chk("stall_wdata", 32'(map_wdata), 32'(p_data));
      end
      if (reset && map_req && map_gnt) begin
         n_acc++;
         chk("access_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("acc_we",   32'(map_we),   32'(e.we));
            chk("acc_addr", 32'(map_addr), 32'(e.addr));
            if (e.we) chk("acc_wdata", 32'(map_wdata), 32'(e.data));
            if (map_we && map_wdata == 2'b11) w11_cnt++;
            if (map_we && map_wdata == 2'b00) w00_cnt++;
         end
      end
      p_pend = reset && map_req && !map_gnt;
      p_we   = map_we;
      p_addr = map_addr;
      p_data = map_wdata;
      @(posedge clk);
      #1;
      if (gnt_rand_en) gnt_rnd = ($urandom_range(0, 3) != 0);
   endtask

   // Reference planner: appends the expected access sequence of one event.
   task automatic plan_event(input int x, input int y);
      int col, row, nr, nc, a, t;
      int rec[$];
      int dr[4] = '{-1, 1, 0, 0};
      int dc[4] = '{0, 0, -1, 1};
      if (x < XO || y < YO) return;
      col = (x - XO) / 16;
      row = (y - YO) / 16;
      if (col >= COLS || row >= ROWS) return;
      a = row * COLS + col;
      exp_q.push_back('{1'b1, 9'(a), 2'b11});
      rec.push_back(a);
      for (int k = 0; k < 4; k++) begin
         for (int d = 1; d <= RANGE; d++) begin
            nr = row + dr[k] * d;
            nc = col + dc[k] * d;
            if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) break;
            a = nr * COLS + nc;
            exp_q.push_back('{1'b0, 9'(a), 2'b00});
            t = int'(shadow[a]);
            if (t == 1) break;
            exp_q.push_back('{1'b1, 9'(a), 2'b11});
            rec.push_back(a);
            if (t == 2) break;
         end
      end
      foreach (rec[i]) begin
         exp_q.push_back('{1'b1, 9'(rec[i]), 2'b00});
         shadow[rec[i]] = 2'b00;
      end
   endtask

   task automatic fire(input int x, input int y);
      ev_x = 10'(x);
      ev_y = 10'(y);
      ev_valid = 1'b1;
      tick();
      ev_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      chk("finish_in_budget", 32'(k < budget), 32'd1);
      tick();
      tick();
   endtask

   task automatic load_map();
      ld_en = 1'b1;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic check_map(input string tag);
      mism = 0;
      for (int i = 0; i < NT; i++) if (mem[i] !== shadow[i]) mism++;
      chk(tag, 32'(mism), 32'd0);
   endtask

   task automatic clr_counts();
      act_cnt = 0; done_cnt = 0; w11_cnt = 0; w00_cnt = 0; n_acc = 0;
   endtask

   initial begin
      int x, y;
      clr_counts();
      for (int i = 0; i < NT; i++) shadow[i] = 2'b00;

      // Reset state
      ld_en = 1'b1;
      reset = 1'b0;
      tick();
      tick();
      ld_en = 1'b0;
      chk("rst_map_req",      32'(map_req),      32'd0);
      chk("rst_busy",         32'(busy),         32'd0);
      chk("rst_blast_active", 32'(blast_active), 32'd0);
      chk("rst_blast_done",   32'(blast_done),   32'd0);
      chk("rst_ev_overflow",  32'(ev_overflow),  32'd0);
      chk("rst_map_we",       32'(map_we),       32'd0);
      chk("rst_map_addr",     32'(map_addr),     32'd0);
      reset = 1'b1;
      tick();

      // Open field: pixel (112,96) is tile (4,4)
      clr_counts();
      plan_event(112, 96);
      ev_x = 10'd112; ev_y = 10'd96; ev_valid = 1'b1;
      tick();
      ev_valid = 1'b0;
      chk("req_at_T+1", 32'(map_req), 32'd0);
      tick();
      chk("req_at_T+2", 32'(map_req), 32'd1);
      wait_idle(500);
      chk("open_w11",   32'(w11_cnt),  32'd9);
      chk("open_w00",   32'(w00_cnt),  32'd9);
      chk("open_hold",  32'(act_cnt),  32'(HOLD));
      chk("open_done",  32'(done_cnt), 32'd1);
      check_map("open_map");

      // Obstacles: wall above, breakable to the right
      clr_counts();
      shadow[3 * COLS + 4] = 2'b01;
      shadow[4 * COLS + 5] = 2'b10;
      load_map();
      plan_event(112, 96);
      fire(112, 96);
      wait_idle(500);
      chk("obst_w11",       32'(w11_cnt), 32'd6);
      chk("obst_breakable", 32'(mem[4 * COLS + 5]), 32'd0);
      chk("obst_wall",      32'(mem[3 * COLS + 4]), 32'd1);
      check_map("obst_map");

      // Map edge: tile (0,0), then an off-map event
      clr_counts();
      plan_event(48, 32);
      fire(48, 32);
      wait_idle(500);
      chk("edge_w11", 32'(w11_cnt), 32'd5);
      clr_counts();
      fire(40, 100);
      for (int i = 0; i < 10; i++) tick();
      chk("offmap_access", 32'(n_acc), 32'd0);
      chk("offmap_busy",   32'(busy),  32'd0);

      // Grant stall at the first arm read
      clr_counts();
      shadow[3 * COLS + 4] = 2'b10;
      load_map();
      plan_event(112, 96);
      gnt_man = 1'b0;
      fire(112, 96);
      n = 0;
      while (!map_req && n < 10) begin tick(); n++; end
      chk("stall_center_req", 32'(map_req), 32'd1);
      gnt_man = 1'b1;
      tick();
      gnt_man = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("stall_req_held", 32'(map_req),  32'd1);
      chk("stall_is_read",  32'(map_we),   32'd0);
      chk("stall_rd_addr",  32'(map_addr), 32'(3 * COLS + 4));
      gnt_man = 1'b1;
      wait_idle(500);
      check_map("stall_map");

      // Random maps, positions and grants
      gnt_rand_en = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NT; i++) shadow[i] = 2'($urandom_range(0, 3));
         load_map();
         x = int'($urandom_range(30, 600));
         y = int'($urandom_range(20, 290));
         plan_event(x, y);
         fire(x, y);
         wait_idle(2000);
         check_map("rand_map");
      end
      gnt_rand_en = 1'b0;

      // Queue: six events while busy, four kept in order, two dropped
      clr_counts();
      for (int i = 0; i < NT; i++) shadow[i] = 2'b00;
      load_map();
      plan_event(112, 96);
      fire(112, 96);
      n = 0;
      while (!map_req && n < 10) begin tick(); n++; end
      for (int k = 0; k < 6; k++) begin
         x = int'($urandom_range(48, 570));
         y = int'($urandom_range(32, 270));
         if (k < 4) plan_event(x, y);
         fire(x, y);
         tick();
      end
      chk("queue_overflow", 32'(ev_overflow), 32'd1);
      wait_idle(3000);
      chk("queue_done",        32'(done_cnt),    32'd5);
      chk("queue_overflow_st", 32'(ev_overflow), 32'd1);
      check_map("queue_map");

      // Reset during HOLD aborts everything, including a queued event
      plan_event(200, 150);
      fire(200, 150);
      n = 0;
      while (!blast_active && n < 100) begin tick(); n++; end
      chk("hold_reached", 32'(blast_active), 32'd1);
      fire(300, 200);
      reset = 1'b0;
      tick();
      chk("rst2_busy",         32'(busy),         32'd0);
      chk("rst2_blast_active", 32'(blast_active), 32'd0);
      chk("rst2_map_req",      32'(map_req),      32'd0);
      chk("rst2_ev_overflow",  32'(ev_overflow),  32'd0);
      reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NT; i++) shadow[i] = mem[i];
      clr_counts();
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
      chk("rst2_fifo_empty", 32'(busy_cnt), 32'd0);
      chk("rst2_no_access",  32'(n_acc),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
